// File: rtl/axi_lite_wrr_arbiter.sv
// Weighted round-robin arbiter for AXI-Lite address channels.
// Registered one-hot grant held until handshake or requester withdrawal.
module axi_lite_wrr_arbiter #(
    parameter int N        = 4,
    parameter int WEIGHT_W = 4,
    localparam int IDX_W   = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          req,
    input  logic [N*WEIGHT_W-1:0] weight,
    input  logic                  handshake_complete,
    output logic [N-1:0]          grant,
    output logic                  grant_valid,
    output logic [IDX_W-1:0]      grant_idx
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                state_reg;
    logic [N-1:0]          grant_reg;
    logic                  grant_valid_reg;
    logic [IDX_W-1:0]      grant_idx_reg;
    logic [IDX_W-1:0]      ptr_reg;
    logic [WEIGHT_W-1:0]   credit_reg [N];

    logic [WEIGHT_W-1:0]   weight_eff [N];
    logic [N-1:0]          credit_nz;
    logic [N-1:0]          eligible;
    logic [N-1:0]          cand;
    logic                  reload;
    logic                  found;
    logic [IDX_W-1:0]      win;
    logic [N-1:0]          grant_next;
    int                    start_pos;
    int                    pos;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            assign credit_nz[gi]  = |credit_reg[gi];
            // A zero weight still earns one grant per round so nobody starves.
            assign weight_eff[gi] = (weight[gi*WEIGHT_W +: WEIGHT_W] == '0)
                                    ? WEIGHT_W'(1) : weight[gi*WEIGHT_W +: WEIGHT_W];
        end
    endgenerate

    assign eligible = req & credit_nz;
    assign reload   = (eligible == '0);

    // Last winner with credit left keeps the bus; otherwise rotate from ptr+1.
    always_comb begin
        cand       = reload ? req : eligible;
        start_pos  = reload ? ((int'(ptr_reg) + 1) % N) : int'(ptr_reg);
        found      = 1'b0;
        win        = '0;
        pos        = 0;
        grant_next = '0;
        for (int k = 0; k < N; k++) begin
            pos = (start_pos + k) % N;
            if (!found && cand[pos]) begin
                found = 1'b1;
                win   = IDX_W'(pos);
            end
        end
        grant_next[win] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            grant_reg       <= '0;
            grant_valid_reg <= 1'b0;
            grant_idx_reg   <= '0;
            ptr_reg         <= IDX_W'(N - 1);
            for (int i = 0; i < N; i++) credit_reg[i] <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|req) begin
                        if (reload) begin
                            for (int i = 0; i < N; i++) credit_reg[i] <= weight_eff[i];
                        end
                        grant_reg       <= grant_next;
                        grant_valid_reg <= 1'b1;
                        grant_idx_reg   <= win;
                        state_reg       <= GRANT;
                    end
                end
                GRANT: begin
                    if (handshake_complete) begin
                        if (credit_nz[grant_idx_reg]) begin
                            credit_reg[grant_idx_reg] <= credit_reg[grant_idx_reg] - WEIGHT_W'(1);
                        end
                        ptr_reg         <= grant_idx_reg;
                        grant_reg       <= '0;
                        grant_valid_reg <= 1'b0;
                        grant_idx_reg   <= '0;
                        state_reg       <= IDLE;
                    end else if (!req[grant_idx_reg]) begin
                        // Withdrawn request: drop the grant without charging credit.
                        grant_reg       <= '0;
                        grant_valid_reg <= 1'b0;
                        grant_idx_reg   <= '0;
                        state_reg       <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign grant       = grant_reg;
    assign grant_valid = grant_valid_reg;
    assign grant_idx   = grant_idx_reg;

endmodule

// File: tb/tb_axi_lite_wrr_arbiter.sv
// Directed plus randomized checks of the WRR arbiter against a behavioural model.
module tb_axi_lite_wrr_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] weight = '0;
    logic           handshake_complete = 1'b0;
    logic [N-1:0]   grant;
    logic           grant_valid;
    logic [1:0]     grant_idx;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    int m_busy;
    int m_idx;
    int m_ptr;
    int m_credit [N];

    axi_lite_wrr_arbiter #(.N(N), .WEIGHT_W(W)) dut (
        .clk                (clk),
        .rst                (rst),
        .req                (req),
        .weight             (weight),
        .handshake_complete (handshake_complete),
        .grant              (grant),
        .grant_valid        (grant_valid),
        .grant_idx          (grant_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int next_in_ring(input logic [N-1:0] mask, input int from);
        for (int k = 0; k < N; k++) begin
            if (mask[(from + k) % N]) return (from + k) % N;
        end
        return 0;
    endfunction

    task automatic model_step(input logic r, input logic [N-1:0] rq, input logic h);
        logic [N-1:0] elig;
        if (r) begin
            m_busy = 0; m_idx = 0; m_ptr = N - 1;
            for (int i = 0; i < N; i++) m_credit[i] = 0;
        end else if (m_busy == 0) begin
            if (rq != 0) begin
                elig = '0;
                for (int i = 0; i < N; i++) elig[i] = rq[i] && (m_credit[i] > 0);
                if (elig == 0) begin
                    for (int i = 0; i < N; i++) begin
                        m_credit[i] = int'(weight[i*W +: W]);
                        if (m_credit[i] == 0) m_credit[i] = 1;
                    end
                    m_idx = next_in_ring(rq, (m_ptr + 1) % N);
                end else if (elig[m_ptr]) begin
                    m_idx = m_ptr;
                end else begin
                    m_idx = next_in_ring(elig, (m_ptr + 1) % N);
                end
                m_busy = 1;
            end
        end else if (h) begin
            if (m_credit[m_idx] > 0) m_credit[m_idx]--;
            m_ptr  = m_idx;
            m_busy = 0;
        end else if (!rq[m_idx]) begin
            m_busy = 0;
        end
    endtask

    task automatic cycle(input logic r, input logic [N-1:0] rq, input logic h);
        logic [N-1:0] exp_grant;
        @(negedge clk);
        rst = r; req = rq; handshake_complete = h;
        model_step(r, rq, h);
        @(posedge clk);
        #1;
        exp_grant = '0;
        if (m_busy != 0) exp_grant[m_idx] = 1'b1;
        check("grant", 32'(grant), 32'(exp_grant));
        check("grant_valid", 32'(grant_valid), 32'(m_busy != 0));
        check("grant_idx", 32'(grant_idx), (m_busy != 0) ? 32'(m_idx) : 32'd0);
        $display("t=%0t rst=%0b req=%b hs=%0b -> grant=%b valid=%0b idx=%0d",
                 $time, r, rq, h, grant, grant_valid, grant_idx);
    endtask

    int exp_seq30 [5] = '{0, 1, 2, 3, 0};
    int exp_seq31 [8] = '{0, 0, 0, 1, 0, 0, 0, 1};

    initial begin
        model_step(1'b1, '0, 1'b0);

        // Single requester: 1-cycle latency, held until handshake.
        weight = {4'd1, 4'd1, 4'd1, 4'd1};
        cycle(1'b1, 4'b0000, 1'b0);
        cycle(1'b0, 4'b0001, 1'b0);
        check("basic_grant", 32'(grant), 32'h1);
        cycle(1'b0, 4'b0001, 1'b0);
        cycle(1'b0, 4'b0001, 1'b1);
        check("basic_release", 32'(grant), 32'h0);

        // Equal weights, all requesting: plain rotation with bubbles.
        cycle(1'b1, 4'b0000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 4'b1111, 1'b0);
            check("rr_winner", 32'(grant_idx), 32'(exp_seq30[i]));
            cycle(1'b0, 4'b1111, 1'b1);
            check("rr_bubble", 32'(grant_valid), 32'h0);
        end

        // Weight 3 vs 1.
        weight = {4'd1, 4'd1, 4'd1, 4'd3};
        cycle(1'b1, 4'b0000, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 4'b0011, 1'b0);
            check("wrr_winner", 32'(grant_idx), 32'(exp_seq31[i]));
            cycle(1'b0, 4'b0011, 1'b1);
        end

        // Grant held while other requests toggle.
        weight = {4'd1, 4'd1, 4'd1, 4'd1};
        cycle(1'b1, 4'b0000, 1'b0);
        cycle(1'b0, 4'b0011, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, (i % 2 == 0) ? 4'b0001 : 4'b0011, 1'b0);
            check("hold_grant", 32'(grant), 32'h1);
        end
        cycle(1'b0, 4'b0011, 1'b1);

        // Abort on withdrawn request keeps ptr and credit.
        cycle(1'b1, 4'b0000, 1'b0);
        cycle(1'b0, 4'b0010, 1'b0);
        check("abort_pre", 32'(grant), 32'h2);
        cycle(1'b0, 4'b0000, 1'b0);
        check("abort_drop", 32'(grant), 32'h0);
        cycle(1'b0, 4'b0110, 1'b0);
        check("abort_regrant", 32'(grant), 32'h2);

        // Reset beats handshake; zero weights act as one.
        cycle(1'b1, 4'b1111, 1'b1);
        check("rst_over_hs", 32'({grant, grant_valid, grant_idx}), 32'h0);
        weight = '0;
        cycle(1'b0, 4'b1000, 1'b0);
        check("zero_weight", 32'(grant), 32'h8);
        cycle(1'b0, 4'b1000, 1'b1);
        cycle(1'b0, 4'b1000, 1'b0);
        check("zero_weight_again", 32'(grant), 32'h8);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic [N-1:0] rq;
            logic h;
            logic r;
            if ($urandom_range(0, 19) == 0) weight = N*W'($urandom());
            rq = N'($urandom());
            h  = ($urandom_range(0, 2) == 0);
            r  = ($urandom_range(0, 59) == 0);
            cycle(r, rq, h);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
